// File: rtl/systolic_skew_feeder_if.sv
// rtl/systolic_skew_feeder_if.sv - handshake/data bundle between the upstream source, the skew feeder and the PE array edge
// The o_bubbles member exists only when SKEW_FEEDER_STATS_EN is defined.
interface systolic_skew_feeder_if #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int KW = 8
);
    logic          i_start;
    logic [KW-1:0] i_k;
    logic          i_mode;
    logic          i_valid;
    logic          o_ready;
    logic [N*W-1:0] i_data;
    logic [N*W-1:0] o_lane;
    logic          o_en;
    logic          o_mode;
    logic          o_busy;
    logic          o_done;
    logic          i_ack;
`ifdef SKEW_FEEDER_STATS_EN
    logic [KW-1:0] o_bubbles;

    modport master (
        output i_start, i_k, i_mode, i_valid, i_data, i_ack,
        input  o_ready, o_lane, o_en, o_mode, o_busy, o_done, o_bubbles
    );
    modport slave (
        input  i_start, i_k, i_mode, i_valid, i_data, i_ack,
        output o_ready, o_lane, o_en, o_mode, o_busy, o_done, o_bubbles
    );
`else
    modport master (
        output i_start, i_k, i_mode, i_valid, i_data, i_ack,
        input  o_ready, o_lane, o_en, o_mode, o_busy, o_done
    );
    modport slave (
        input  i_start, i_k, i_mode, i_valid, i_data, i_ack,
        output o_ready, o_lane, o_en, o_mode, o_busy, o_done
    );
`endif
endinterface

// File: rtl/systolic_skew_feeder.sv
// rtl/systolic_skew_feeder.sv - diagonal-skew operand feeder for one edge of an NxN systolic array
// Optional SKEW_FEEDER_STATS_EN adds the saturating o_bubbles counter.
module systolic_skew_feeder #(
    parameter int W  = 16,
    parameter int N  = 4,
    parameter int KW = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    systolic_skew_feeder_if.slave bus
);
    localparam int FW = (2 * N > 2) ? $clog2(2 * N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, HOLD} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [KW-1:0]  k_q;
    logic [KW-1:0]  count;
    logic [FW-1:0]  flush_cnt;
    logic           mode_q;
    logic           start_ok;
    logic           accept;
    logic [N*W-1:0] push_vec;
    logic [N*W-1:0] lane_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            k_q       <= '0;
            count     <= '0;
            flush_cnt <= '0;
            mode_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                k_q    <= bus.i_k;
                mode_q <= bus.i_mode;
                count  <= '0;
            end else if (accept) begin
                count <= count + 1'b1;
            end
            if (state == FLUSH) flush_cnt <= flush_cnt + 1'b1;
            else                flush_cnt <= '0;
        end
    end

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start && (bus.i_k != '0)) begin
                    start_ok  = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                accept = bus.i_valid;
                if (accept && (count == k_q - 1'b1)) state_nxt = FLUSH;
            end
            FLUSH: begin
                // 2N-1 zero cycles carry the last wavefront into PE[N-1][N-1]'s input register
                if (flush_cnt == FW'(2 * N - 2)) state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.i_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Bubbles and flush both push zeros; PEs stay enabled since zero operands leave sums intact
    assign push_vec = accept ? bus.i_data : '0;

    for (genvar j = 0; j < N; j++) begin : g_lane
        logic [W-1:0] sr [0:j];

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int s = 0; s <= j; s++) sr[s] <= '0;
            end else begin
                sr[0] <= push_vec[j*W +: W];
                for (int s = 1; s <= j; s++) sr[s] <= sr[s-1];
            end
        end

        assign lane_q[j*W +: W] = sr[j];
    end

    assign bus.o_lane  = lane_q;
    assign bus.o_ready = (state == LOAD);
    assign bus.o_en    = (state != IDLE);
    assign bus.o_busy  = (state != IDLE);
    assign bus.o_done  = (state == HOLD);
    assign bus.o_mode  = mode_q;

`ifdef SKEW_FEEDER_STATS_EN
    logic [KW-1:0] bubbles;

    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            bubbles <= '0;
        end else if ((state == LOAD) && !accept && (bubbles != '1)) begin
            bubbles <= bubbles + 1'b1;
        end
    end

    assign bus.o_bubbles = bubbles;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb/tb_systolic_skew_feeder.sv - directed table-driven bench for systolic_skew_feeder (N=4, W=16)
module tb_systolic_skew_feeder;
    localparam int W  = 16;
    localparam int N  = 4;
    localparam int KW = 8;
    localparam logic [63:0] Z = '0;

    typedef struct {
        int          st;
        int          k;
        int          md;
        int          vl;
        logic [63:0] d;
        int          ak;
        logic [63:0] el;
        int          er;
        int          een;
        int          ebu;
        int          edn;
        int          emd;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t tbl [15];
    logic [63:0] expb [16];

    always #5 clk = ~clk;

    systolic_skew_feeder_if #(.W(W), .N(N), .KW(KW)) bus ();

    systolic_skew_feeder #(.W(W), .N(N), .KW(KW)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    function automatic logic [63:0] p4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic vec_t mk(input int st, input int k, input int md, input int vl,
                                input logic [63:0] d, input int ak, input logic [63:0] el,
                                input int er, input int een, input int ebu, input int edn, input int emd);
        vec_t v;
        v.st = st; v.k = k; v.md = md; v.vl = vl; v.d = d; v.ak = ak;
        v.el = el; v.er = er; v.een = een; v.ebu = ebu; v.edn = edn; v.emd = emd;
        return v;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [63:0] el, input int er, input int een,
                             input int ebu, input int edn, input int emd);
        check({nm, " lane"},  bus.o_lane, el);
        check({nm, " ready"}, 64'(bus.o_ready), 64'(er));
        check({nm, " en"},    64'(bus.o_en),    64'(een));
        check({nm, " busy"},  64'(bus.o_busy),  64'(ebu));
        check({nm, " done"},  64'(bus.o_done),  64'(edn));
        check({nm, " mode"},  64'(bus.o_mode),  64'(emd));
    endtask

    task automatic drive(input int st, input int k, input int md, input int vl,
                         input logic [63:0] d, input int ak);
        bus.i_start = (st != 0);
        bus.i_k     = KW'(k);
        bus.i_mode  = (md != 0);
        bus.i_valid = (vl != 0);
        bus.i_data  = d;
        bus.i_ack   = (ak != 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ff;
        ff = p4(16'hffff, 16'hffff, 16'hffff, 16'hffff);

        // k=3, mode=1, valid always high; start in LOAD and ack in FLUSH must be ignored
        tbl[0]  = mk(1, 3, 1, 1, p4(1, 2, 3, 4),    0, Z,                 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 1, p4(1, 2, 3, 4),    0, Z,                 1, 1, 1, 0, 1);
        tbl[2]  = mk(1, 9, 0, 1, p4(5, 6, 7, 8),    0, p4(1, 0, 0, 0),    1, 1, 1, 0, 1);
        tbl[3]  = mk(0, 0, 0, 1, p4(9, 10, 11, 12), 0, p4(5, 2, 0, 0),    1, 1, 1, 0, 1);
        tbl[4]  = mk(0, 0, 0, 1, ff,                0, p4(9, 6, 3, 0),    0, 1, 1, 0, 1);
        tbl[5]  = mk(0, 0, 0, 1, ff,                1, p4(0, 10, 7, 4),   0, 1, 1, 0, 1);
        tbl[6]  = mk(0, 0, 0, 1, ff,                0, p4(0, 0, 11, 8),   0, 1, 1, 0, 1);
        tbl[7]  = mk(0, 0, 0, 1, ff,                0, p4(0, 0, 0, 12),   0, 1, 1, 0, 1);
        tbl[8]  = mk(0, 0, 0, 1, ff,                0, Z,                 0, 1, 1, 0, 1);
        tbl[9]  = mk(0, 0, 0, 1, ff,                0, Z,                 0, 1, 1, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, ff,                0, Z,                 0, 1, 1, 0, 1);
        tbl[11] = mk(0, 0, 0, 1, ff,                0, Z,                 0, 1, 1, 1, 1);
        tbl[12] = mk(0, 0, 0, 1, ff,                1, Z,                 0, 1, 1, 1, 1);
        tbl[13] = mk(1, 1, 0, 1, ff,                0, Z,                 0, 0, 0, 0, 1);
        tbl[14] = mk(0, 0, 0, 1, p4(1, 2, 3, 4),    0, Z,                 1, 1, 1, 0, 0);

        for (int c = 0; c < 16; c++) expb[c] = Z;
        expb[2] = p4(1, 0, 0, 0);
        expb[3] = p4(0, 2, 0, 0);
        expb[4] = p4(0, 0, 3, 0);
        expb[5] = p4(5, 0, 0, 4);
        expb[6] = p4(9, 6, 0, 0);
        expb[7] = p4(0, 10, 7, 0);
        expb[8] = p4(0, 0, 11, 8);
        expb[9] = p4(0, 0, 0, 12);

        rst = 1'b1;
        drive(0, 0, 0, 0, Z, 0);
        tick();
        tick();
        @(negedge clk);
        check_all("reset", Z, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        drive(1, 0, 1, 1, p4(1, 2, 3, 4), 0);
        @(negedge clk);
        check_all("k0 start", Z, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, Z, 0);
        @(negedge clk);
        check_all("k0 after", Z, 0, 0, 0, 0, 0);
        tick();

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].st, tbl[i].k, tbl[i].md, tbl[i].vl, tbl[i].d, tbl[i].ak);
            @(negedge clk);
            check_all($sformatf("tbl c%0d", i), tbl[i].el, tbl[i].er, tbl[i].een,
                      tbl[i].ebu, tbl[i].edn, tbl[i].emd);
`ifdef SKEW_FEEDER_STATS_EN
            if (i == 11) check("tbl bubbles", 64'(bus.o_bubbles), 64'd0);
`endif
            tick();
        end

        rst = 1'b1;
        drive(0, 0, 0, 0, Z, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_all("post reset", Z, 0, 0, 0, 0, 0);
        tick();

        // two bubbles between vector 1 and vector 2
        for (int c = 0; c <= 15; c++) begin
            case (c)
                0:       drive(1, 3, 1, 0, Z, 0);
                1:       drive(0, 0, 0, 1, p4(1, 2, 3, 4), 0);
                2, 3:    drive(0, 0, 0, 0, p4(5, 6, 7, 8), 0);
                4:       drive(0, 0, 0, 1, p4(5, 6, 7, 8), 0);
                5:       drive(0, 0, 0, 1, p4(9, 10, 11, 12), 0);
                14:      drive(0, 0, 0, 0, Z, 1);
                default: drive(0, 0, 0, 0, Z, 0);
            endcase
            @(negedge clk);
            check_all($sformatf("bub c%0d", c), expb[c],
                      int'(c >= 1 && c <= 5), int'(c >= 1 && c <= 14), int'(c >= 1 && c <= 14),
                      int'(c >= 13 && c <= 14), int'(c >= 1));
`ifdef SKEW_FEEDER_STATS_EN
            if (c == 13 || c == 15) check($sformatf("bub c%0d bubbles", c), 64'(bus.o_bubbles), 64'd2);
`endif
            tick();
        end

        // reset in the middle of FLUSH
        drive(1, 1, 1, 0, Z, 0);
        @(negedge clk);
        tick();
        drive(0, 0, 0, 1, p4(1, 2, 3, 4), 0);
        @(negedge clk);
        check_all("rf load", Z, 1, 1, 1, 0, 1);
        tick();
        drive(0, 0, 0, 0, Z, 0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check_all("rf flush", p4(0, 2, 0, 0), 0, 1, 1, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_all("rf reset", Z, 0, 0, 0, 0, 0);
        tick();

        // clean pass after reset, long HOLD, ack, back-to-back start
        for (int c = 0; c <= 22; c++) begin
            logic [63:0] el;
            el = Z;
            case (c)
                0:       drive(1, 2, 0, 0, Z, 0);
                1:       drive(0, 0, 0, 1, p4(21, 22, 23, 24), 0);
                2:       drive(0, 0, 0, 1, p4(31, 32, 33, 34), 0);
                20:      drive(0, 0, 0, 0, Z, 1);
                21:      drive(1, 1, 1, 0, Z, 0);
                default: drive(0, 0, 0, 0, Z, 0);
            endcase
            case (c)
                2:       el = p4(21, 0, 0, 0);
                3:       el = p4(31, 22, 0, 0);
                4:       el = p4(0, 32, 23, 0);
                5:       el = p4(0, 0, 33, 24);
                6:       el = p4(0, 0, 0, 34);
                default: el = Z;
            endcase
            @(negedge clk);
            check_all($sformatf("hold c%0d", c), el,
                      int'(c == 1 || c == 2 || c == 22), int'((c >= 1 && c <= 20) || c == 22),
                      int'((c >= 1 && c <= 20) || c == 22), int'(c >= 10 && c <= 20), int'(c == 22));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Edge feeder for the N×N systolic PE array: accepts one N-lane operand vector per cycle over a valid/ready handshake and drives it onto the array edge with diagonal skew, so lane j arrives j cycles after lane 0. It generates the array enable and mode for a whole pass. It drains the wavefront with zero fill, then holds results until the downstream result reader acknowledges. One instance feeds the A edge and one feeds the B edge.

## Interface
- W, 16, operand width per lane
- N, 4, lanes (array dimension)
- KW, 8, width of pass-length count
- i_clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous reset, active high
- i_start  in  1  begin a pass; sampled only in IDLE
- i_k  in  KW  vectors in the pass; latched with i_start
- i_mode  in  1  MAC mode for the pass; latched with i_start
- i_valid  in  1  upstream vector valid
- o_ready  out  1  feeder accepts a vector this cycle
- i_data  in  N*W  vector; lane j = i_data[j*W +: W]
- o_lane  out  N*W  skewed edge outputs, registered; lane j = o_lane[j*W +: W]
- o_en  out  1  array enable (PE i_en)
- o_mode  out  1  latched mode (PE i_mode)
- o_busy  out  1  pass in progress (state ≠ IDLE)
- o_done  out  1  results valid in array, level, held until i_ack
- i_ack  in  1  result reader has captured all PE outputs

## Operation
- States: IDLE, LOAD, FLUSH, HOLD.
- IDLE: o_en=0, o_ready=0. i_start with i_k≠0 latches k and mode, clears the accepted count, and moves to LOAD. i_start with i_k=0 is ignored.
- LOAD: o_ready=1 while count<k. An accept (i_valid&o_ready) pushes i_data into the skew lines and increments count.
  - No accept: a zero vector is pushed (bubble). Zero operands add 0 to every PE accumulator, so o_en stays high and partial sums survive.
  - The cycle of the k-th accept moves to FLUSH; o_ready is 0 from the next cycle.
- FLUSH: pushes zero vectors for exactly 2N-1 cycles (wavefront reaches PE[N-1][N-1] plus the PE input register), then moves to HOLD.
- HOLD: o_done=1 and o_en=1, skew lines zero. i_ack moves to IDLE; o_en drops the next cycle, which clears the PEs.
- Skew: lane j passes through j+1 registers. A vector accepted at edge t appears on lane 0 after edge t+1 and on lane j after edge t+1+j.
- o_mode is constant for the whole pass; it changes only on the IDLE→LOAD transition.
- The count is KW bits, so k up to 2^KW−1. No wrap is possible because the count stops at k.
- i_start outside IDLE is ignored. i_ack outside HOLD is ignored.
- Reset in any state: state IDLE, all skew registers 0, count 0, outputs at reset values.

## Timing
- Reset values: o_lane=0, o_en=0, o_mode=0, o_ready=0, o_busy=0, o_done=0 (and o_bubbles=0 when configured).
- o_en, o_busy, o_ready and o_done are all registered state decodes:
  - o_en=1 and o_busy=1 from the cycle after i_start through the cycle of i_ack.
  - o_ready=1 from the first LOAD cycle through the cycle of the k-th accept.
- Minimum pass with no bubbles: 1 (start) + k + 2N−1 cycles until o_done rises.
- o_ready does not depend combinationally on i_valid. i_valid may depend on o_ready.
- Back-to-back passes: i_start is accepted in the first IDLE cycle after i_ack.

## Configuration
- SKEW_FEEDER_STATS_EN defined: adds output o_bubbles (KW bits).
  - Counts bubble cycles in LOAD and saturates at all-ones.
  - Cleared on i_start acceptance and on reset; holds its value through FLUSH, HOLD and IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- N=4, k=3, vectors {1,2,3,4},{5,6,7,8},{9,10,11,12}, i_valid always 1 → lane0 shows 1,5,9 on cycles 2–4 after start; lane3 shows 4,8,12 on cycles 5–7; o_done rises on cycle 11 (1+3+7).
- Same stimulus with i_valid low for 2 cycles between vectors 1 and 2 → two zero vectors on every lane in the gap, o_en stays 1, o_done one cycle per bubble later (cycle 13), o_bubbles=2.
- i_start with i_k=0 → state stays IDLE, o_busy=0, o_en=0.
- i_rst asserted during FLUSH → next cycle all o_lane=0, o_en=0, o_busy=0; a subsequent i_start runs a clean pass.
- HOLD with i_ack low for 10 cycles → o_done and o_en stay 1, o_lane stays 0. i_ack pulse → IDLE; o_en=0 the next cycle; i_start the following cycle is accepted.
- i_start pulsed during LOAD with a different i_k and i_mode → ignored; the pass length and o_mode are unchanged.
